// File: rtl/triangle_voice_scheduler.sv
// Shares one 2-cycle triangle_wave generator across NUM_VOICES phase-accumulator
// voices. Each sample_tick sequences all voices and emits one mixed sample.

module triangle_wave (
    input  logic        clk,
    input  logic        rst,
    input  logic [14:0] phase,
    output logic [11:0] sample
);
    logic [11:0] r_stage1;
    logic [11:0] r_stage2;

    // Rising ramp over the first half of the phase period, falling over the second
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage1 <= '0;
            r_stage2 <= '0;
        end else begin
            r_stage1 <= phase[14] ? ~phase[13:2] : phase[13:2];
            r_stage2 <= r_stage1;
        end
    end

    assign sample = r_stage2;
endmodule

module triangle_voice_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int ACC_W      = 24,
    parameter int SAMPLE_W   = 12,
    localparam int IDX_W     = $clog2(NUM_VOICES),
    localparam int SUM_W     = SAMPLE_W + IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_tick,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_addr,
    input  logic [ACC_W-1:0]  cfg_tune,
    input  logic              cfg_en,
    output logic [SUM_W-1:0]  mix,
    output logic              mix_valid,
    output logic              busy,
    output logic              overrun
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_drainCnt;
    logic [ACC_W-1:0]      r_acc      [NUM_VOICES];
    logic [ACC_W-1:0]      r_tune     [NUM_VOICES];
    logic [ACC_W-1:0]      r_shTune   [NUM_VOICES];
    logic [NUM_VOICES-1:0] r_en;
    logic [NUM_VOICES-1:0] r_shEn;
    logic                  r_tag1;
    logic                  r_tag2;
    logic [SUM_W-1:0]      r_sum;
    logic [SUM_W-1:0]      r_mix;
    logic                  r_mixValid;
    logic                  r_overrun;
    logic                  w_accept;
    logic                  w_issue;
    logic [14:0]           w_phase;
    logic [SAMPLE_W-1:0]   w_sample;

    triangle_wave u_tri (
        .clk    (clk),
        .rst    (rst),
        .phase  (w_phase),
        .sample (w_sample)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (sample_tick) w_nextState = ISSUE;
            ISSUE:   if (r_idx == IDX_W'(NUM_VOICES - 1)) w_nextState = DRAIN;
            DRAIN:   if (r_drainCnt) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state != IDLE);
        w_issue  = (r_state == ISSUE);
        w_accept = (r_state == IDLE) && sample_tick;
        w_phase  = w_issue ? r_acc[r_idx][ACC_W-1 -: 15] : 15'd0;
    end

    // Frames run from shadow copies so config writes only land at the next frame
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                r_acc[v]    <= '0;
                r_tune[v]   <= '0;
                r_shTune[v] <= '0;
            end
            r_en       <= '0;
            r_shEn     <= '0;
            r_idx      <= '0;
            r_drainCnt <= 1'b0;
            r_tag1     <= 1'b0;
            r_tag2     <= 1'b0;
            r_sum      <= '0;
            r_mix      <= '0;
            r_mixValid <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            if (cfg_we) begin
                r_tune[cfg_addr] <= cfg_tune;
                r_en[cfg_addr]   <= cfg_en;
            end
            if (w_accept) begin
                for (int v = 0; v < NUM_VOICES; v++) r_shTune[v] <= r_tune[v];
                r_shEn     <= r_en;
                r_idx      <= '0;
                r_drainCnt <= 1'b0;
            end
            if (w_issue) begin
                r_acc[r_idx] <= r_shEn[r_idx] ? r_acc[r_idx] + r_shTune[r_idx] : '0;
                r_idx        <= r_idx + 1'b1;
            end
            if (r_state == DRAIN) r_drainCnt <= ~r_drainCnt;
            // Tag tracks the generator latency so only this frame's enabled samples are summed
            r_tag1 <= w_issue && r_shEn[r_idx];
            r_tag2 <= r_tag1;
            if (w_accept)    r_sum <= '0;
            else if (r_tag2) r_sum <= r_sum + SUM_W'(w_sample);
            if (r_state == DONE) r_mix <= r_sum;
            r_mixValid <= (r_state == DONE);
            if (sample_tick && r_state != IDLE) r_overrun <= 1'b1;
        end
    end

    assign mix       = r_mix;
    assign mix_valid = r_mixValid;
    assign overrun   = r_overrun;
endmodule

// File: tb/tb_triangle_voice_scheduler.sv
// Directed plus randomized checks of triangle_voice_scheduler against a frame-level
// model built from accumulator, enable and triangle-shape rules.

module tb_triangle_voice_scheduler;
    localparam int N     = 4;
    localparam int ACC_W = 24;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_tick;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [23:0] cfg_tune;
    logic        cfg_en;
    logic [13:0] mix;
    logic        mix_valid;
    logic        busy;
    logic        overrun;

    int errors = 0;
    int checks = 0;

    int mTune [N];
    int mAcc  [N];
    bit mEn   [N];
    bit mOverrun;

    triangle_voice_scheduler #(.NUM_VOICES(N), .ACC_W(ACC_W), .SAMPLE_W(12)) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_tune    (cfg_tune),
        .cfg_en      (cfg_en),
        .mix         (mix),
        .mix_valid   (mix_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int triRef(input int ph);
        if (ph < 16384) return ph / 4;
        return (32767 - ph) / 4;
    endfunction

    // One whole frame: pre-increment phase per voice, then advance or zero the accumulator
    function automatic int modelFrame();
        int s = 0;
        for (int v = 0; v < N; v++) begin
            if (mEn[v]) begin
                s += triRef(mAcc[v] >> (ACC_W - 15));
                mAcc[v] = (mAcc[v] + mTune[v]) & 24'hFFFFFF;
            end else begin
                mAcc[v] = 0;
            end
        end
        return s;
    endfunction

    task automatic resetDut();
        rst = 1'b1;
        sample_tick = 1'b0;
        cfg_we = 1'b0;
        cfg_addr = '0;
        cfg_tune = '0;
        cfg_en = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int v = 0; v < N; v++) begin
            mTune[v] = 0;
            mAcc[v] = 0;
            mEn[v] = 1'b0;
        end
        mOverrun = 1'b0;
        checkOutput("reset_mix", mix, 0);
        checkOutput("reset_valid", mix_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_overrun", overrun, 0);
    endtask

    task automatic cfgWrite(input int addr, input int tune, input bit en);
        cfg_we = 1'b1;
        cfg_addr = 2'(addr);
        cfg_tune = 24'(tune);
        cfg_en = en;
        @(posedge clk);
        #1 cfg_we = 1'b0;
        mTune[addr] = tune & 24'hFFFFFF;
        mEn[addr] = en;
    endtask

    task automatic applyStimulus(input string tag, input bit wrAtTick, input bit wrMid,
                                 input bit extraTick, input int wAddr, input int wTune,
                                 input bit wEn);
        int expMix;
        int c;
        bit got;
        sample_tick = 1'b1;
        if (wrAtTick || wrMid) begin
            cfg_addr = 2'(wAddr);
            cfg_tune = 24'(wTune);
            cfg_en = wEn;
        end
        cfg_we = wrAtTick;
        expMix = modelFrame();
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        cfg_we = 1'b0;
        if (wrAtTick) begin
            mTune[wAddr] = wTune & 24'hFFFFFF;
            mEn[wAddr] = wEn;
        end
        checkOutput({tag, "_busy"}, busy, 1);
        c = 0;
        got = 1'b0;
        while (!got && c < 20) begin
            if (c == 1) begin
                sample_tick = extraTick;
                cfg_we = wrMid;
            end
            @(posedge clk);
            #1;
            c++;
            if (c == 2) begin
                sample_tick = 1'b0;
                cfg_we = 1'b0;
                if (extraTick) mOverrun = 1'b1;
                if (wrMid) begin
                    mTune[wAddr] = wTune & 24'hFFFFFF;
                    mEn[wAddr] = wEn;
                end
            end
            if (mix_valid) got = 1'b1;
        end
        checkOutput({tag, "_latency"}, c, N + 3);
        checkOutput({tag, "_mix"}, mix, expMix);
        @(posedge clk);
        #1;
        checkOutput({tag, "_pulse"}, mix_valid, 0);
        checkOutput({tag, "_idle"}, busy, 0);
        checkOutput({tag, "_overrun"}, overrun, mOverrun);
        repeat (2) @(posedge clk);
        #1 checkOutput({tag, "_hold"}, mix, expMix);
    endtask

    initial begin
        int pulses;
        resetDut();

        applyStimulus("all_off", 0, 0, 0, 0, 0, 0);

        cfgWrite(0, 24'h000200, 1);
        repeat (3) applyStimulus("v0_step", 0, 0, 0, 0, 0, 0);
        checkOutput("v0_acc", dut.r_acc[0], 24'h000600);

        resetDut();
        for (int v = 0; v < N; v++) cfgWrite(v, 24'hFFFE00, 1);
        repeat (2) applyStimulus("wrap", 0, 0, 0, 0, 0, 0);

        resetDut();
        cfgWrite(0, 24'h123456, 1);
        cfgWrite(1, 24'h654321, 1);
        cfgWrite(2, 24'hABCDEF, 1);
        cfgWrite(3, 24'h0F0F0F, 1);
        repeat (3) applyStimulus("mixed", 0, 0, 0, 0, 0, 0);

        applyStimulus("overrun", 0, 0, 1, 0, 0, 0);
        applyStimulus("overrun_hold", 0, 0, 0, 0, 0, 0);

        applyStimulus("wr_at_tick", 1, 0, 0, 1, 24'h3A0000, 1);
        applyStimulus("wr_new1", 0, 0, 0, 0, 0, 0);
        applyStimulus("wr_mid", 0, 1, 0, 1, 24'h07F000, 1);
        applyStimulus("wr_new2", 0, 1, 0, 2, 24'h000000, 0);
        applyStimulus("wr_new3", 0, 0, 0, 0, 0, 0);

        // Abort in DRAIN: no pulse may follow, and the next frame restarts from phase 0
        sample_tick = 1'b1;
        @(posedge clk);
        #1 sample_tick = 1'b0;
        repeat (N + 1) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int v = 0; v < N; v++) begin
            mTune[v] = 0;
            mAcc[v] = 0;
            mEn[v] = 1'b0;
        end
        mOverrun = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_mix", mix, 0);
        checkOutput("abort_overrun", overrun, 0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 if (mix_valid) pulses++;
        end
        checkOutput("abort_no_valid", pulses, 0);
        cfgWrite(2, 24'h2468AC, 1);
        repeat (2) applyStimulus("after_abort", 0, 0, 0, 0, 0, 0);

        for (int it = 0; it < 25; it++) begin
            int nw;
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++)
                cfgWrite($urandom_range(0, N - 1), $urandom & 24'hFFFFFF, 1'($urandom_range(0, 3) != 0));
            applyStimulus("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
                          $urandom_range(0, N - 1), $urandom & 24'hFFFFFF, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/triangle_voice_scheduler.md
Name: triangle_voice_scheduler

Overview:
- Time-multiplexes one shared triangle_wave generator across NUM_VOICES independent oscillator voices.
- The generator takes a 15-bit phase and returns a 12-bit sample with a 2-cycle registered latency.
- On each sample_tick, the block sequences every voice's phase through the generator, advances each voice's phase accumulator, sums the enabled voices' samples, and presents one mixed sample to the audio path.
- A simple register-style config port sets per-voice tuning words and enables.

Parameters:
- NUM_VOICES, 4: number of voices; power of two, 2..16.
- ACC_W, 24: phase accumulator width; top 15 bits drive the generator phase.
- SAMPLE_W, 12: generator sample width; fixed by triangle_wave.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- sample_tick  input  1  one-cycle pulse that starts a frame.
- cfg_we  input  1  config write strobe.
- cfg_addr  input  clog2(NUM_VOICES)  voice index for the config write.
- cfg_tune  input  ACC_W  tuning word (phase increment per frame).
- cfg_en  input  1  voice enable.
- mix  output  SAMPLE_W+clog2(NUM_VOICES)  unsigned sum of enabled voice samples.
- mix_valid  output  1  one-cycle pulse; mix updated in the same cycle.
- busy  output  1  high while a frame is in progress.
- overrun  output  1  sticky flag: a tick arrived while busy.

Behaviour:
- Reset (clk, rst synchronous active-high):
  - Clears all accumulators, tune, en, shadow registers, the sum, and the FSM (to IDLE).
  - mix=0, mix_valid=0, busy=0, overrun=0.
  - The instantiated triangle_wave receives the same rst.
- Config:
  - cfg_we writes tune[cfg_addr] and en[cfg_addr] on the next edge, in any state.
  - Frames use shadow copies latched at tick acceptance, so writes take effect at the next frame.
  - A write that coincides with tick acceptance is NOT seen by that frame.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
  - IDLE: busy=0. If sample_tick=1, latch shadows, clear sum and voice index i, go to ISSUE.
  - ISSUE: one cycle per voice. Drive phase = acc[i][ACC_W-1:ACC_W-15]. Update acc[i] += shadow_tune[i] (mod 2^ACC_W) if shadow_en[i]; else acc[i] is forced to 0. After voice NUM_VOICES-1, go to DRAIN.
  - DRAIN: 2 cycles for generator latency. The accumulate pipeline adds the returning sample (zeroed if that voice is disabled) into sum. Go to DONE.
  - DONE: mix <= sum (including the final voice), mix_valid=1 for exactly this cycle, then IDLE.
- Latency and timing:
  - Tick sampled at edge k: ISSUE occupies edges k+1..k+N, and mix_valid is high after edge k+N+3.
  - Total frame = N+3 cycles; next tick accepted in IDLE.
- The phase presented for a voice is its pre-increment value. The first frame after enable uses phase 0.
- Returned samples are tagged by a 2-stage delayed copy of (valid, voice-enable), so the sum never includes stale generator output.
- Width: sum width SAMPLE_W+clog2(N); no overflow possible; no saturation or scaling.
- Overrun:
  - sample_tick while busy (ISSUE/DRAIN/DONE) is ignored and sets overrun=1.
  - overrun clears only on rst.
- Hold: mix holds its last value between frames.
- Reset mid-frame: abort immediately, all state to reset values, no mix_valid.
- Phase is also driven to 0 while idle.

Test Plan:
- Reset, then tick with all voices disabled -> mix_valid after exactly N+3 = 7 cycles; mix=0; all accumulators stay 0.
- Voice 0 en, tune=0x000200; ticks 1..3 -> phases presented 0, 1, 2; mix equals golden triangle(0), triangle(1), triangle(2); acc[0]=0x000600 after the 3rd frame.
- All 4 voices en, tune=0xFFFE00; 2 frames -> frame 2 phase = 0x7FFF for each voice (wrap); mix = 4*triangle(0x7FFF).
- Tick issued 2 cycles after an accepted tick -> ignored, overrun=1, single mix_valid; overrun holds across later frames until rst.
- cfg write of voice 1 tune on the tick-accept edge and mid-ISSUE -> current frame uses the old tune; the next frame uses the new one.
- rst asserted in DRAIN -> busy=0, mix=0, no mix_valid; the next tick produces a clean frame starting from phase 0.
